// File: rtl/multi_pipe_pkg.sv
// Shared types and helpers for the pipelined shift-and-add multiplier tree.
package multi_pipe_pkg;

  typedef enum logic {MUL_UNSIGNED, MUL_SIGNED} mul_mode_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_pipe_level.sv
// One adder-tree level: N operands in, N/2 registered pairwise sums out, with valid and tag.
module multi_pipe_level
  import multi_pipe_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PW    = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic                       in_valid,
  input  logic [N-1:0][PW-1:0]       in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  output logic [N/2-1:0][PW-1:0]     out_data,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int unsigned NO = N / 2;

  logic [NO-1:0][PW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < NO; j++) begin
      sum[j] = in_data[2*j] + in_data[2*j+1];
    end
  end

  // Data and tag hold on bubbles so the outputs only change when real work arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= sum;
        out_tag  <= in_tag;
      end
    end
  end

endmodule

// File: rtl/multi_pipe_tree.sv
// Pipelined shift-and-add multiplier: partial products summed by a registered binary tree.
module multi_pipe_tree
  import multi_pipe_pkg::*;
#(
  parameter int unsigned WIDTH_A = 4,
  parameter int unsigned WIDTH_B = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_signed,
  input  logic [WIDTH_A-1:0]         mul_a,
  input  logic [WIDTH_B-1:0]         mul_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] mul_out,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int unsigned PW  = WIDTH_A + WIDTH_B;
  localparam int unsigned LAT = clog2(WIDTH_A);
  localparam int unsigned NP  = 1 << LAT;

  mul_mode_t mode;
  logic [PW-1:0]          ext_b;
  logic [PW-1:0]          term;
  logic [NP-1:0][PW-1:0]  pp_bus;

  // Heap-ordered tree: leaves at [2NP-1:NP], node m sums children 2m and 2m+1, root is node 1.
  logic [2*NP-1:1][PW-1:0]   node;
  logic [LAT:0]              lvl_v;
  logic [LAT:0][TAG_W-1:0]   lvl_tag;
  logic [LAT+1:1]            adv;

  assign mode  = in_signed ? MUL_SIGNED : MUL_UNSIGNED;
  assign ext_b = {{WIDTH_A{(mode == MUL_SIGNED) & mul_b[WIDTH_B-1]}}, mul_b};

  always_comb begin
    pp_bus = '0;
    term   = '0;
    for (int unsigned i = 0; i < WIDTH_A; i++) begin
      term = mul_a[i] ? (ext_b << i) : '0;
      if (mode == MUL_SIGNED && i == WIDTH_A - 1) term = -term;
      pp_bus[i] = term;
    end
  end

  assign node[2*NP-1:NP] = pp_bus;
  assign lvl_v[0]        = in_valid;
  assign lvl_tag[0]      = in_tag;

  always_comb begin
    adv        = '0;
    adv[LAT+1] = out_ready;
    for (int unsigned k = LAT; k >= 1; k--) begin
      adv[k] = ~lvl_v[k] | adv[k+1];
    end
  end

  for (genvar k = 1; k <= LAT; k++) begin : g_lvl
    localparam int unsigned N_IN = NP >> (k - 1);
    multi_pipe_level #(
      .N     (N_IN),
      .PW    (PW),
      .TAG_W (TAG_W)
    ) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv[k]),
      .in_valid  (lvl_v[k-1]),
      .in_data   (node[2*N_IN-1:N_IN]),
      .in_tag    (lvl_tag[k-1]),
      .out_valid (lvl_v[k]),
      .out_data  (node[N_IN-1:N_IN/2]),
      .out_tag   (lvl_tag[k])
    );
  end

  assign in_ready  = adv[1];
  assign out_valid = lvl_v[LAT];
  assign mul_out   = node[1];
  assign out_tag   = lvl_tag[LAT];

endmodule

// File: tb/tb_multi_pipe_tree.sv
// Directed checks of the multiplier tree at 4x4 (LAT=2) and 8x8 (LAT=3).
module tb_multi_pipe_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4x4 instance
  logic       a_in_valid = 1'b0, a_in_ready, a_in_signed = 1'b0;
  logic [3:0] a_mul_a = '0, a_mul_b = '0, a_in_tag = '0;
  logic       a_out_valid, a_out_ready = 1'b1;
  logic [7:0] a_mul_out;
  logic [3:0] a_out_tag;

  // 8x8 instance
  logic        b_in_valid = 1'b0, b_in_ready, b_in_signed = 1'b0;
  logic [7:0]  b_mul_a = '0, b_mul_b = '0;
  logic [3:0]  b_in_tag = '0;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic [15:0] b_mul_out;
  logic [3:0]  b_out_tag;

  multi_pipe_tree #(.WIDTH_A(4), .WIDTH_B(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_signed(a_in_signed), .mul_a(a_mul_a), .mul_b(a_mul_b), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .mul_out(a_mul_out), .out_tag(a_out_tag)
  );

  multi_pipe_tree #(.WIDTH_A(8), .WIDTH_B(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_signed(b_in_signed), .mul_a(b_mul_a), .mul_b(b_mul_b), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .mul_out(b_mul_out), .out_tag(b_out_tag)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic s, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] t);
    a_in_valid = v; a_in_signed = s; a_mul_a = a; a_mul_b = b; a_in_tag = t;
  endtask

  task automatic expect_a(input string tag, input logic [7:0] prod, input logic [3:0] t);
    check({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    check({tag, "_prod"},  32'(a_mul_out),   32'(prod));
    check({tag, "_tag"},   32'(a_out_tag),   32'(t));
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_prod",  32'(a_mul_out),   32'd0);
    check("rst_tag",   32'(a_out_tag),   32'd0);
    check("rst_ready", 32'(a_in_ready),  32'd1);
    check("rst_valid8", 32'(b_out_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Unsigned 15*15, latency 2
    drive_a(1, 0, 4'd15, 4'd15, 4'd5);
    tick(); drive_a(0, 0, 0, 0, 0);
    check("lat_early", 32'(a_out_valid), 32'd0);
    tick();
    expect_a("u15x15", 8'hE1, 4'd5);
    tick();
    check("u15x15_done", 32'(a_out_valid), 32'd0);

    // Signed back-to-back
    drive_a(1, 1, 4'h8, 4'h7, 4'd1);
    tick(); drive_a(1, 1, 4'h8, 4'h8, 4'd2);
    tick(); drive_a(1, 1, 4'hF, 4'h1, 4'd3);
    expect_a("s_m8x7", 8'hC8, 4'd1);
    tick(); drive_a(0, 0, 0, 0, 0);
    expect_a("s_m8xm8", 8'h40, 4'd2);
    tick();
    expect_a("s_m1x1", 8'hFF, 4'd3);
    tick();
    check("signed_done", 32'(a_out_valid), 32'd0);

    // Stall: capacity 2, then release in order
    a_out_ready = 1'b0;
    drive_a(1, 0, 4'd2, 4'd3, 4'd1);
    tick(); drive_a(1, 0, 4'd3, 4'd3, 4'd2);
    check("stall_ready1", 32'(a_in_ready), 32'd1);
    tick(); drive_a(1, 0, 4'd4, 4'd4, 4'd3);
    check("stall_full", 32'(a_in_ready), 32'd0);
    expect_a("stall_hold", 8'd6, 4'd1);
    tick();
    expect_a("stall_stable", 8'd6, 4'd1);
    a_out_ready = 1'b1;
    #1;
    check("ready_path", 32'(a_in_ready), 32'd1);
    tick(); drive_a(0, 0, 0, 0, 0);
    expect_a("rel_t2", 8'd9, 4'd2);
    tick();
    expect_a("rel_t3", 8'd16, 4'd3);
    tick();
    check("rel_done", 32'(a_out_valid), 32'd0);

    // Bubble collapse behind a stalled output
    a_out_ready = 1'b0;
    drive_a(1, 0, 4'd5, 4'd3, 4'd7);
    tick(); drive_a(0, 0, 0, 0, 0);
    tick();
    check("bub_ready", 32'(a_in_ready), 32'd1);
    expect_a("bub_head", 8'd15, 4'd7);
    drive_a(1, 0, 4'd2, 4'd2, 4'd8);
    tick(); drive_a(0, 0, 0, 0, 0);
    check("bub_full", 32'(a_in_ready), 32'd0);
    expect_a("bub_head2", 8'd15, 4'd7);
    a_out_ready = 1'b1;
    tick();
    expect_a("bub_next", 8'd4, 4'd8);
    tick();
    check("bub_done", 32'(a_out_valid), 32'd0);

    // Reset with two items in flight
    drive_a(1, 0, 4'd3, 4'd5, 4'd9);
    tick(); drive_a(1, 0, 4'd6, 4'd2, 4'd10);
    tick(); drive_a(0, 0, 0, 0, 0);
    check("pre_rst_valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_prod",  32'(a_mul_out),   32'd0);
    check("mid_rst_tag",   32'(a_out_tag),   32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", 32'(a_out_valid), 32'd0);
    end

    // 8x8, latency 3
    b_in_valid = 1'b1; b_in_signed = 1'b0; b_mul_a = 8'd255; b_mul_b = 8'd255; b_in_tag = 4'd3;
    tick(); b_in_valid = 1'b0;
    check("w8_lat1", 32'(b_out_valid), 32'd0);
    tick();
    check("w8_lat2", 32'(b_out_valid), 32'd0);
    tick();
    check("w8_u_valid", 32'(b_out_valid), 32'd1);
    check("w8_u_prod",  32'(b_mul_out),   32'hFE01);
    check("w8_u_tag",   32'(b_out_tag),   32'd3);
    b_in_valid = 1'b1; b_in_signed = 1'b1; b_mul_a = 8'h80; b_mul_b = 8'h80; b_in_tag = 4'd4;
    tick(); b_mul_a = 8'hFD; b_mul_b = 8'd5; b_in_tag = 4'd6;
    tick(); b_in_valid = 1'b0;
    tick();
    check("w8_s_prod", 32'(b_mul_out), 32'h4000);
    check("w8_s_tag",  32'(b_out_tag), 32'd4);
    tick();
    check("w8_s2_prod", 32'(b_mul_out), 32'hFFF1);
    check("w8_s2_tag",  32'(b_out_tag), 32'd6);
    tick();
    check("w8_done", 32'(b_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
